// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multicycle FSM states, opcodes and datapath select encodings.
// Used by the multicycle controller and the single-cycle decoders.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    UPPER    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  localparam logic [2:0] ALU_FUNCT  = 3'b010;
  localparam logic [2:0] ALU_UPPER  = 3'b100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational immediate-format decode from the opcode, independent of FSM state.
module imm_src_decoder
  import cpu_pkg::*;
#(
  parameter int OP_WIDTH      = 7,
  parameter int IMM_SRC_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0]      op,
  output logic [IMM_SRC_WIDTH-1:0] imm_src
);

  logic [6:0] opc;
  logic [2:0] imm;

  assign opc = 7'(op);

  always_comb begin
    imm = IMM_I;
    case (opc)
      OP_LOAD, OP_ITYPE: imm = IMM_I;
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_LUI, OP_AUIPC:  imm = IMM_U;
      OP_JAL:            imm = IMM_J;
      default:           imm = IMM_I;
    endcase
  end

  assign imm_src = IMM_SRC_WIDTH'(imm);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory, ALU and branch steps
// over a unified memory with a handshake, and drives the datapath selects.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int IMM_SRC_WIDTH = 3,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int OP_WIDTH      = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [OP_WIDTH-1:0]      op,
  input  logic                     branch_taken,
  input  logic                     mem_ack,
  output logic                     mem_req,
  output logic                     AdrSrc,
  output logic                     IRWrite,
  output logic                     PCWrite,
  output logic                     MemWrite,
  output logic                     RegWrite,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALU_OP_WIDTH-1:0]  ALUOp,
  output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
  output logic                     illegal_op
);

  state_t     state, next_state;
  logic [6:0] opc;
  logic       ack;
  logic       pc_update;
  logic       branch;
  logic [2:0] alu_op;

  assign opc = 7'(op);

  // Masking ack with reset keeps IRWrite/PCWrite/MemWrite low while held in reset.
  assign ack = mem_ack & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALU_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (ack) begin
          IRWrite    = 1'b1;
          pc_update  = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opc)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECR;
          OP_ITYPE:          next_state = EXECI;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_LUI, OP_AUIPC:  next_state = UPPER;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (opc == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (ack) next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = ack;
        if (ack) next_state = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALU_BRANCH;
        branch     = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      UPPER: begin
        // LUI adds the immediate to zero; AUIPC adds it to the instruction's own PC.
        ALUSrcA    = (opc == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALU_UPPER;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & branch_taken);
  assign ALUOp   = ALU_OP_WIDTH'(alu_op);

  imm_src_decoder #(
    .OP_WIDTH      (OP_WIDTH),
    .IMM_SRC_WIDTH (IMM_SRC_WIDTH)
  ) u_imm_src_decoder (
    .op      (op),
    .imm_src (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares every control output against hand-computed values.
module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RTY   = 7'b0110011;
  localparam logic [6:0] ITY   = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JALOP = 7'b1101111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       branch_taken;
  logic       mem_ack;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp, ImmSrc;
  logic [18:0] observed;

  int vectors     = 0;
  int miscompares = 0;

  multicycle_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ImmSrc       (ImmSrc),
    .illegal_op   (illegal_op)
  );

  always #5 clk = ~clk;

  assign observed = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op};

  task automatic applyStimulus(input logic [6:0] o, input logic ack, input logic tk);
    op = o;
    mem_ack = ack;
    branch_taken = tk;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [18:0] got, input logic [18:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (mreq adr irw pcw mw rw rs a b aluop imm ill)",
               tag, got, exp);
    end
  endtask

  task automatic expectOut(input string tag, input logic mr, input logic adr, input logic irw,
                           input logic pcw, input logic mw, input logic rw, input logic [1:0] rs,
                           input logic [1:0] a, input logic [1:0] b, input logic [2:0] aop,
                           input logic [2:0] imm, input logic ill);
    checkOutput(tag, observed, {mr, adr, irw, pcw, mw, rw, rs, a, b, aop, imm, ill});
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  // Zero-wait fetch followed by a legal decode; leaves the FSM in the execute state.
  task automatic fetchDecode(input string tag, input logic [6:0] o, input logic [2:0] imm);
    applyStimulus(o, 1'b1, 1'b0);
    expectOut({tag, "_fetch"}, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
    nextCycle();
    applyStimulus(o, 1'b0, 1'b0);
    expectOut({tag, "_decode"}, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0);
    nextCycle();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(LW, 1'b1, 1'b0);
    #1;
    expectOut("reset", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    nextCycle();
    rst_n = 1'b1;

    // Load, zero wait states: five cycles, RegWrite only in the last.
    fetchDecode("lw", LW, 3'b000);
    applyStimulus(LW, 1'b0, 1'b0);
    expectOut("lw_memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0);
    nextCycle();
    applyStimulus(LW, 1'b1, 1'b0);
    expectOut("lw_memread", 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    nextCycle();
    applyStimulus(LW, 1'b0, 1'b0);
    expectOut("lw_memwb", 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    nextCycle();

    // Fetch stalled three cycles, then R-type.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(RTY, 1'b0, 1'b0);
      expectOut("fetch_wait", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
      nextCycle();
    end
    fetchDecode("r", RTY, 3'b000);
    applyStimulus(RTY, 1'b0, 1'b0);
    expectOut("r_exec", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0);
    nextCycle();
    applyStimulus(RTY, 1'b0, 1'b0);
    expectOut("r_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    nextCycle();

    // Branch taken then not taken.
    fetchDecode("beq_t", BEQ, 3'b010);
    applyStimulus(BEQ, 1'b0, 1'b1);
    expectOut("beq_taken", 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
    nextCycle();
    fetchDecode("beq_n", BEQ, 3'b010);
    applyStimulus(BEQ, 1'b0, 1'b0);
    expectOut("beq_not_taken", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0);
    nextCycle();

    // Unsupported opcode: pulse in DECODE, straight back to FETCH.
    applyStimulus(BAD, 1'b1, 1'b0);
    expectOut("bad_fetch", 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    nextCycle();
    applyStimulus(BAD, 1'b0, 1'b0);
    expectOut("illegal_decode", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1);
    nextCycle();
    applyStimulus(BAD, 1'b0, 1'b0);
    expectOut("illegal_refetch", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    nextCycle();

    // Store abandoned by an asynchronous reset before the ack arrives.
    fetchDecode("sw_rst", SW, 3'b001);
    applyStimulus(SW, 1'b0, 1'b0);
    expectOut("sw_memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0);
    nextCycle();
    applyStimulus(SW, 1'b0, 1'b0);
    expectOut("sw_wait", 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    rst_n = 1'b0;
    applyStimulus(SW, 1'b1, 1'b0);
    expectOut("reset_async", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(SW, 1'b0, 1'b0);
    expectOut("reset_refetch", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 0);
    nextCycle();

    // Complete store: four cycles, MemWrite in the ack cycle.
    fetchDecode("sw", SW, 3'b001);
    applyStimulus(SW, 1'b0, 1'b0);
    expectOut("sw2_memadr", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0);
    nextCycle();
    applyStimulus(SW, 1'b1, 1'b0);
    expectOut("sw_write", 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0);
    nextCycle();

    // LUI then AUIPC.
    fetchDecode("lui", LUI, 3'b011);
    applyStimulus(LUI, 1'b0, 1'b0);
    expectOut("lui_upper", 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 3'b011, 0);
    nextCycle();
    applyStimulus(LUI, 1'b0, 1'b0);
    expectOut("lui_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 0);
    nextCycle();
    fetchDecode("auipc", AUIPC, 3'b011);
    applyStimulus(AUIPC, 1'b0, 1'b0);
    expectOut("auipc_upper", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b100, 3'b011, 0);
    nextCycle();
    applyStimulus(AUIPC, 1'b0, 1'b0);
    expectOut("auipc_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 0);
    nextCycle();

    // I-type with a stray ack during DECODE and EXECI, which must be ignored.
    applyStimulus(ITY, 1'b1, 1'b0);
    expectOut("i_fetch", 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
    nextCycle();
    applyStimulus(ITY, 1'b1, 1'b0);
    expectOut("i_decode_ack", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0);
    nextCycle();
    applyStimulus(ITY, 1'b1, 1'b0);
    expectOut("i_exec", 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0);
    nextCycle();
    applyStimulus(ITY, 1'b0, 1'b0);
    expectOut("i_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    nextCycle();

    // JAL.
    fetchDecode("jal", JALOP, 3'b100);
    applyStimulus(JALOP, 1'b0, 1'b0);
    expectOut("jal_exec", 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 0);
    nextCycle();
    applyStimulus(JALOP, 1'b0, 1'b0);
    expectOut("jal_aluwb", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100, 0);
    nextCycle();
    applyStimulus(JALOP, 1'b0, 1'b0);
    expectOut("jal_refetch", 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
